uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
//
// PURPOSE
//   Shares one UART transmitter among N_REQ byte sources. Each source offers a byte on a
//   valid/ready handshake, and the arbiter grants sources in round-robin order. It applies
//   that source's parity configuration, issues a one-cycle tx_start to the UART TX, and
//   tracks tx_busy until the frame completes. It sits between the byte producers and the
//   UART TX, and drives that block's tx_start, data_in, parity_en and even_parity inputs.
//
// PARAMETERS
//   N_REQ        4    number of requesters (>= 2)
//   BUSY_TIMEOUT 16   max cycles after tx_start for tx_busy to rise (>= 2)
//   IDW          $clog2(N_REQ)  grant index width (localparam)
//
// PORTS
//   clk             in   1         system clock, all logic on rising edge
//   rst             in   1         synchronous reset, active-high
//   req_valid       in   N_REQ     per-source byte offered
//   req_data        in   8*N_REQ   source i byte at [8*i+7:8*i]
//   req_ready       out  N_REQ     one-cycle accept pulse, one-hot
//   cfg_parity_en   in   N_REQ     per-source parity enable
//   cfg_even_parity in   N_REQ     per-source parity type (1=even, 0=odd)
//   tx_start        out  1         one-cycle start pulse to UART TX
//   data_in         out  8         byte to UART TX
//   parity_en       out  1         parity enable to UART TX
//   even_parity     out  1         parity type to UART TX
//   tx_busy         in   1         UART TX frame in progress
//   grant_id        out  IDW       index of the current/last granted source
//   err_timeout     out  1         one-cycle pulse: tx_busy never rose after tx_start
//
// BEHAVIOUR
//   - Reset: state=IDLE, rr_ptr=0, req_ready=0, tx_start=0, data_in=0, parity_en=0,
//     even_parity=0, grant_id=0, err_timeout=0. Reset mid-frame abandons the grant.
//     tx_start stays low from the cycle after rst is sampled.
//   - All outputs are registered.
//   - FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
//   - IDLE: if tx_busy=0 and any req_valid:
//       - g = first set req_valid at or after rst_ptr order, i.e. scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
//       - Latch req_data[g], cfg_parity_en[g], cfg_even_parity[g] into data_in/parity_en/
//         even_parity, and set grant_id=g. Go to START.
//     If tx_busy=1 in IDLE (foreign or leftover frame), wait; do not grant.
//   - START (exactly 1 cycle): tx_start=1, req_ready[g]=1, timeout counter cleared.
//     Go to WAIT_BUSY. Latency: valid sampled at T -> tx_start and req_ready high at T+1.
//   - WAIT_BUSY: count cycles.
//       - tx_busy=1 -> WAIT_DONE.
//       - Count reaches BUSY_TIMEOUT with tx_busy still 0 -> err_timeout=1 for 1 cycle,
//         rr_ptr=(g+1) mod N_REQ, go to IDLE. The byte is dropped; it is not retried.
//   - WAIT_DONE: tx_busy=0 -> rr_ptr=(g+1) mod N_REQ, go to IDLE.
//     The next grant can occur in that IDLE cycle, giving tx_start 2 cycles after busy falls.
//   - data_in, parity_en and even_parity hold stable from START until the next grant.
//     The cfg_* inputs are sampled only at grant; changes mid-frame do not affect the frame.
//   - Sources hold req_valid/req_data stable until req_ready. Dropping valid before ready
//     withdraws the offer without error. Valid for a source already granted is ignored
//     until the FSM returns to IDLE.
//   - rr_ptr wraps N_REQ-1 -> 0. A lone requester is granted back-to-back.
//   - Simultaneous valids: strict rotation from rr_ptr. No source waits more than N_REQ-1
//     frames.
//   - Exactly one tx_start per grant; tx_start is never asserted while tx_busy=1.
//
// TESTING
//   1 Reset, single source 2 sends 0xA5 with parity_en=1, even=1
//       -> req_ready[2] and tx_start pulse together 1 cycle after valid.
//       -> data_in=0xA5, parity_en=1, even_parity=1, grant_id=2.
//   2 All 4 valid continuously, UART model busy 10 cycles per frame
//       -> grant order 0,1,2,3,0; exactly one tx_start per frame; none while tx_busy=1.
//   3 Only source 3 valid, then sources 0 and 3 valid after its frame
//       -> rr_ptr wraps to 0; source 0 is granted next.
//   4 UART model never raises tx_busy
//       -> err_timeout pulses BUSY_TIMEOUT cycles after tx_start.
//       -> FSM returns to IDLE; next source is granted.
//   5 Toggle cfg_even_parity[1] mid-frame for source 1
//       -> even_parity output unchanged until the next grant.
//   6 Assert rst in WAIT_DONE
//       -> all outputs return to reset values; next grant starts from source 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte sources.
// Latches the granted byte and its parity config, pulses tx_start and tracks tx_busy.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned BUSY_TIMEOUT = 16,
  localparam int unsigned IDW         = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ-1:0]   cfg_parity_en,
  input  logic [N_REQ-1:0]   cfg_even_parity,
  output logic               tx_start,
  output logic [7:0]         data_in,
  output logic               parity_en,
  output logic               even_parity,
  input  logic               tx_busy,
  output logic [IDW-1:0]     grant_id,
  output logic               err_timeout
);

  localparam int unsigned CW = $clog2(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWaitBusy,
    StWaitDone
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic [N_REQ-1:0] req_ready_q, req_ready_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       data_q, data_d;
  logic             parity_en_q, parity_en_d;
  logic             even_parity_q, even_parity_d;
  logic             err_timeout_q, err_timeout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             pick_found;
  logic [IDW-1:0]   pick_idx;
  logic [IDW-1:0]   cand_idx;
  logic [IDW-1:0]   rr_next;

  // First valid source scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand_idx = IDW'((32'(rr_ptr_q) + k) % N_REQ);
      if (!pick_found && req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign rr_next = (grant_id_q == IDW'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    data_d        = data_q;
    parity_en_d   = parity_en_q;
    even_parity_d = even_parity_q;
    cnt_d         = cnt_q;
    req_ready_d   = '0;
    tx_start_d    = 1'b0;
    err_timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A busy UART here is a foreign or leftover frame; hold off granting.
        if (!tx_busy && pick_found) begin
          state_d               = StStart;
          grant_id_d            = pick_idx;
          data_d                = req_data[8*pick_idx +: 8];
          parity_en_d           = cfg_parity_en[pick_idx];
          even_parity_d         = cfg_even_parity[pick_idx];
          tx_start_d            = 1'b1;
          req_ready_d[pick_idx] = 1'b1;
        end
      end
      StStart: begin
        state_d = StWaitBusy;
        cnt_d   = '0;
      end
      StWaitBusy: begin
        if (tx_busy) begin
          state_d = StWaitDone;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 2)) begin
          // Timeout lands BUSY_TIMEOUT cycles after the tx_start cycle; byte is dropped.
          err_timeout_d = 1'b1;
          rr_ptr_d      = rr_next;
          state_d       = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          rr_ptr_d = rr_next;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      req_ready_q   <= '0;
      tx_start_q    <= 1'b0;
      data_q        <= '0;
      parity_en_q   <= 1'b0;
      even_parity_q <= 1'b0;
      err_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      req_ready_q   <= req_ready_d;
      tx_start_q    <= tx_start_d;
      data_q        <= data_d;
      parity_en_q   <= parity_en_d;
      even_parity_q <= even_parity_d;
      err_timeout_q <= err_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_start    = tx_start_q;
  assign data_in     = data_q;
  assign parity_en   = parity_en_q;
  assign even_parity = even_parity_q;
  assign grant_id    = grant_id_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a
// cycle-level reference model of grant order, handshake timing and busy timeout.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int BT  = 16;
  localparam int IDW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready, cfg_parity_en, cfg_even_parity;
  logic [8*N-1:0] req_data;
  logic           tx_start, parity_en, even_parity, tx_busy, err_timeout;
  logic [7:0]     data_in;
  logic [IDW-1:0] grant_id;

  uart_tx_arbiter #(.N_REQ(N), .BUSY_TIMEOUT(BT)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .cfg_parity_en   (cfg_parity_en),
    .cfg_even_parity (cfg_even_parity),
    .tx_start        (tx_start),
    .data_in         (data_in),
    .parity_en       (parity_en),
    .even_parity     (even_parity),
    .tx_busy         (tx_busy),
    .grant_id        (grant_id),
    .err_timeout     (err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Inputs as driven during the cycle that just ended.
  logic [N-1:0]   p_valid, p_pe, p_ep;
  logic [8*N-1:0] p_data;
  logic           p_busy, p_rst;

  // Reference model.
  bit                m_idle = 1'b1, m_open = 1'b0, m_done = 1'b0;
  int                since = 0, rr = 0, cur_g = 0, start_cyc = 0;
  logic [IDW+9:0]    exp_held = '0;
  int                log_q[$];

  // UART model.
  int busy_on = 0, busy_off = 0;
  bit never_busy = 1'b0, rand_uart = 1'b0, refill = 1'b0;
  int d_lo = 1, d_hi = 1, len_lo = 10, len_hi = 10;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int r);
    for (int k = 0; k < N; k++) if (v[(r + k) % N]) return (r + k) % N;
    return -1;
  endfunction

  task automatic tick();
    logic         exp_start, exp_err;
    logic [N-1:0] exp_ready;
    int           g, d;
    p_valid = req_valid; p_data = req_data; p_pe = cfg_parity_en; p_ep = cfg_even_parity;
    p_busy  = tx_busy;   p_rst  = rst;
    @(posedge clk);
    #1;
    cyc++;
    exp_start = 1'b0; exp_err = 1'b0; exp_ready = '0;
    if (p_rst) begin
      m_idle = 1'b1; m_open = 1'b0; m_done = 1'b0; rr = 0; exp_held = '0;
    end else begin
      exp_start = m_idle && (p_valid != '0) && !p_busy;
      if (m_open) begin
        since++;
        if (m_done && !p_busy) begin
          m_open = 1'b0; m_idle = 1'b1; rr = (cur_g + 1) % N;
        end else if (!m_done && since >= 2 && p_busy) begin
          m_done = 1'b1;
        end else if (!m_done && since == BT) begin
          exp_err = 1'b1; m_open = 1'b0; m_idle = 1'b1; rr = (cur_g + 1) % N;
        end
      end
      if (exp_start) begin
        g = pick(p_valid, rr);
        cur_g = g; m_idle = 1'b0; m_open = 1'b1; m_done = 1'b0; since = 0; start_cyc = cyc;
        exp_ready[g] = 1'b1;
        exp_held = {IDW'(g), p_data[8*g +: 8], p_pe[g], p_ep[g]};
        log_q.push_back(g);
      end
    end
    chk("tx_start", 32'(tx_start), 32'(exp_start));
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("err_timeout", 32'(err_timeout), 32'(exp_err));
    chk("held_outputs", 32'({grant_id, data_in, parity_en, even_parity}), 32'(exp_held));
    // Sources: a granted offer is consumed on its ready pulse.
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        if (refill) req_data[8*i +: 8] = 8'($urandom);
        else req_valid[i] = 1'b0;
      end
    end
    if (tx_start) begin
      if (never_busy || (rand_uart && $urandom_range(7) == 0)) begin
        busy_on = -1; busy_off = -1;
      end else begin
        d = int'($urandom_range(d_hi, d_lo));
        busy_on  = cyc + d;
        busy_off = busy_on + int'($urandom_range(len_hi, len_lo));
      end
    end
    tx_busy = (cyc >= busy_on) && (cyc < busy_off);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic offer(input int i, input logic [7:0] b, input logic pe, input logic ep);
    req_valid[i] = 1'b1;
    req_data[8*i +: 8] = b;
    cfg_parity_en[i] = pe;
    cfg_even_parity[i] = ep;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (!(m_idle && !tx_busy && req_valid == '0) && k < 400) begin
      tick();
      k++;
    end
    chk(tag, 32'(k < 400), 32'd1);
  endtask

  task automatic wait_grants(input string tag, input int n);
    int k = 0;
    while (log_q.size() < n && k < 400) begin
      tick();
      k++;
    end
    chk(tag, 32'(log_q.size()), 32'(n));
  endtask

  initial begin : main
    int s4, k;
    rst = 1'b1; req_valid = '0; req_data = '0; cfg_parity_en = '0; cfg_even_parity = '0;
    tx_busy = 1'b0;

    // 1: single source 2, one-cycle latency.
    do_reset();
    offer(2, 8'hA5, 1'b1, 1'b1);
    tick();
    chk("t1_start", 32'(tx_start), 32'd1);
    chk("t1_ready", 32'(req_ready), 32'h4);
    chk("t1_data", 32'(data_in), 32'hA5);
    chk("t1_parity", 32'({parity_en, even_parity}), 32'h3);
    chk("t1_grant", 32'(grant_id), 32'd2);
    wait_idle("t1_idle");

    // 2: all sources continuously valid.
    do_reset();
    log_q.delete();
    refill = 1'b1;
    for (int i = 0; i < N; i++) offer(i, 8'($urandom), 1'($urandom), 1'($urandom));
    wait_grants("t2_grants", 5);
    refill = 1'b0;
    for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), 32'(log_q[i]), 32'(i % N));
    wait_idle("t2_idle");

    // 3: pointer wraps after source 3.
    do_reset();
    log_q.delete();
    offer(3, 8'h5A, 1'b0, 1'b0);
    wait_grants("t3_first", 1);
    chk("t3_g3", 32'(log_q[0]), 32'd3);
    wait_idle("t3_idle1");
    offer(0, 8'h11, 1'b1, 1'b0);
    offer(3, 8'h33, 1'b1, 1'b1);
    wait_grants("t3_second", 2);
    chk("t3_wrap_g0", 32'(log_q[1]), 32'd0);
    wait_idle("t3_idle2");

    // 4: UART never goes busy.
    do_reset();
    log_q.delete();
    never_busy = 1'b1;
    offer(1, 8'hC3, 1'b1, 1'b0);
    offer(2, 8'h3C, 1'b0, 1'b1);
    wait_grants("t4_first", 1);
    s4 = start_cyc;
    chk("t4_g1", 32'(log_q[0]), 32'd1);
    k = 0;
    while (err_timeout !== 1'b1 && k < 60) begin
      tick();
      k++;
    end
    chk("t4_err_delay", 32'(cyc - s4), 32'(BT));
    wait_grants("t4_second", 2);
    chk("t4_next_g2", 32'(log_q[1]), 32'd2);
    chk("t4_next_delay", 32'(start_cyc - s4), 32'(BT + 1));
    wait_idle("t4_idle");
    never_busy = 1'b0;

    // 5: cfg changes mid-frame do not leak out.
    do_reset();
    log_q.delete();
    offer(1, 8'h96, 1'b1, 1'b0);
    wait_grants("t5_grant", 1);
    for (int i = 0; i < 8; i++) begin
      cfg_even_parity[1] = ~cfg_even_parity[1];
      cfg_parity_en[1]   = ~cfg_parity_en[1];
      tick();
    end
    chk("t5_even_hold", 32'(even_parity), 32'd0);
    wait_idle("t5_idle");
    chk("t5_even_after", 32'({parity_en, even_parity}), 32'h2);

    // 6: reset while in WAIT_DONE.
    do_reset();
    log_q.delete();
    offer(1, 8'h01, 1'b0, 1'b0);
    wait_grants("t6_first", 1);
    wait_idle("t6_idle1");
    offer(2, 8'h02, 1'b1, 1'b1);
    wait_grants("t6_second", 2);
    k = 0;
    while (!m_done && k < 30) begin
      tick();
      k++;
    end
    chk("t6_in_done", 32'(m_done), 32'd1);
    tick();
    tick();
    do_reset();
    chk("t6_rst_grant", 32'({grant_id, data_in}), 32'd0);
    chk("t6_rst_pulses", 32'({tx_start, req_ready, err_timeout}), 32'd0);
    offer(1, 8'h71, 1'b0, 1'b1);
    offer(3, 8'h73, 1'b1, 1'b0);
    wait_grants("t6_third", 3);
    chk("t6_from_zero", 32'(log_q[2]), 32'd1);
    wait_idle("t6_idle2");

    // 7: randomized traffic.
    rand_uart = 1'b1; d_lo = 0; d_hi = 3; len_lo = 1; len_hi = 12;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(3) == 0) offer(i, 8'($urandom), 1'b0, 1'b0);
        end else if ($urandom_range(63) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      cfg_parity_en   = N'($urandom);
      cfg_even_parity = N'($urandom);
      tick();
    end
    req_valid = '0;
    wait_idle("t7_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
